// File: rtl/simplez_mem_arbiter_pkg.sv
// Shared Simplez definitions: bus widths, access direction codes, arbiter
// state encoding and the peripheral address map.
package simplez_defs;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 12;
    localparam int BURST_W = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // The top four words of the address space are memory-mapped I/O.
    localparam logic [ADDR_W-1:0] ADDR_PROG_BASE    = 9'h000;
    localparam logic [ADDR_W-1:0] ADDR_PROG_TOP     = 9'h1FB;
    localparam logic [ADDR_W-1:0] ADDR_DISP_STATUS  = 9'h1FC;
    localparam logic [ADDR_W-1:0] ADDR_DISP_DATA    = 9'h1FD;
    localparam logic [ADDR_W-1:0] ADDR_KBD_STATUS   = 9'h1FE;
    localparam logic [ADDR_W-1:0] ADDR_KBD_DATA     = 9'h1FF;

endpackage

// File: rtl/simplez_mem_arbiter_rr_pick.sv
// Two-requester round-robin picker with a bounded burst (lock) mode for
// requester 1; grants are combinational, ownership history is registered.
module simplez_rr_pick
    import simplez_defs::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic req0,
    input  logic req1,
    input  logic lock,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

    arb_state_t         state;
    arb_state_t         state_next;
    logic               last_owner;
    logic               last_owner_next;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_cnt_next;
    logic               burst_ok;

    assign burst_ok = (state == OWN1) && lock && (burst_cnt < BURST_LIMIT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            burst_cnt  <= burst_cnt_next;
        end
    end

    // On a tie, a live burst keeps port 1; otherwise the port that did not
    // own the bus last wins. burst_cnt only advances while port 0 is waiting.
    always_comb begin
        gnt0            = 1'b0;
        gnt1            = 1'b0;
        state_next      = IDLE;
        last_owner_next = last_owner;
        burst_cnt_next  = burst_cnt;

        if (rstn) begin
            if (req0 && !req1) begin
                gnt0 = 1'b1;
            end else if (!req0 && req1) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (burst_ok) begin
                    gnt1 = 1'b1;
                end else if (last_owner) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end
        end

        if (gnt0) begin
            state_next      = OWN0;
            last_owner_next = 1'b0;
        end else if (gnt1) begin
            state_next      = OWN1;
            last_owner_next = 1'b1;
        end

        if (gnt0 || !lock) begin
            burst_cnt_next = '0;
        end else if (gnt1 && req0 && (burst_cnt < BURST_LIMIT)) begin
            burst_cnt_next = burst_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/simplez_mem_arbiter.sv
// Shares the single-port Simplez RAM between the CPU (port 0) and the
// debug/program loader (port 1); read data returns one cycle after the grant.
module simplez_mem_arbiter
    import simplez_defs::*;
#(
    parameter int AW        = ADDR_W,
    parameter int DW        = DATA_W,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             p0_req,
    input  logic             p0_rw,
    input  logic [AW-1:0]    p0_addr,
    input  logic [DW-1:0]    p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    input  logic             p1_req,
    input  logic             p1_rw,
    input  logic [AW-1:0]    p1_addr,
    input  logic [DW-1:0]    p1_wdata,
    input  logic             p1_lock,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [DW-1:0]    rdata,
    output logic             ram_cs,
    output logic             ram_rw,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout,
    output logic [CNT_W-1:0] conflicts
);

    logic p0_rv_q;
    logic p1_rv_q;

    simplez_rr_pick #(
        .MAX_BURST(MAX_BURST)
    ) u_pick (
        .clk  (clk),
        .rstn (rstn),
        .req0 (p0_req),
        .req1 (p1_req),
        .lock (p1_lock),
        .gnt0 (p0_gnt),
        .gnt1 (p1_gnt)
    );

    // An idle bus parks on port 0's address/data with the RAM in read mode.
    always_comb begin
        ram_cs   = p0_gnt | p1_gnt;
        ram_rw   = RW_READ;
        ram_addr = p0_addr;
        ram_din  = p0_wdata;
        if (p1_gnt) begin
            ram_rw   = p1_rw;
            ram_addr = p1_addr;
            ram_din  = p1_wdata;
        end else if (p0_gnt) begin
            ram_rw = p0_rw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            p0_rv_q   <= 1'b0;
            p1_rv_q   <= 1'b0;
            conflicts <= '0;
        end else begin
            p0_rv_q <= p0_gnt & (p0_rw == RW_READ);
            p1_rv_q <= p1_gnt & (p1_rw == RW_READ);
            if (p0_req && p1_req && (conflicts != '1)) begin
                conflicts <= conflicts + 1'b1;
            end
        end
    end

    // A read in flight when reset arrives is dropped immediately, not one cycle later.
    assign p0_rvalid = p0_rv_q & rstn;
    assign p1_rvalid = p1_rv_q & rstn;
    assign rdata     = ram_dout;

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Self-checking bench for simplez_mem_arbiter: directed scenarios plus
// randomized traffic against a rule-level reference model and a RAM stand-in.
module tb_simplez_mem_arbiter;
    import simplez_defs::*;

    localparam int AW        = 9;
    localparam int DW        = 12;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             p0_req = 1'b0, p0_rw = 1'b1;
    logic [AW-1:0]    p0_addr = '0;
    logic [DW-1:0]    p0_wdata = '0;
    logic             p0_gnt, p0_rvalid;
    logic             p1_req = 1'b0, p1_rw = 1'b1, p1_lock = 1'b0;
    logic [AW-1:0]    p1_addr = '0;
    logic [DW-1:0]    p1_wdata = '0;
    logic             p1_gnt, p1_rvalid;
    logic [DW-1:0]    rdata;
    logic             ram_cs, ram_rw;
    logic [AW-1:0]    ram_addr;
    logic [DW-1:0]    ram_din;
    logic [DW-1:0]    ram_dout;
    logic [CNT_W-1:0] conflicts;

    logic             load_mem = 1'b1;
    logic [DW-1:0]    ram_mem [0:(1<<AW)-1];
    logic [DW-1:0]    ref_mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    // reference model state
    int            m_last_owner;
    int            m_run;
    bit            m_prev_p1;
    int            m_conf;
    bit            m_rv0, m_rv1;
    logic [DW-1:0] m_rdata;
    int            last_grant;

    // DUT samples taken at the falling edge of the latest cycle
    logic          dut_g0, dut_g1, dut_rv0, dut_rv1;
    logic [DW-1:0] dut_rdata;
    logic [CNT_W-1:0] dut_conf;

    always #5 clk = ~clk;

    simplez_mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .conflicts(conflicts)
    );

    function automatic logic [DW-1:0] seedVal(input int i);
        return DW'(i * 37 + 5) ^ 12'h5A5;
    endfunction

    // genram stand-in: registered read, write on cs with rw = 0
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= seedVal(i);
        end else if (ram_cs) begin
            if (ram_rw) ram_dout <= ram_mem[ram_addr];
            else        ram_mem[ram_addr] <= ram_din;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_last_owner = 1;
        m_run        = 0;
        m_prev_p1    = 1'b0;
        m_conf       = 0;
        m_rv0        = 1'b0;
        m_rv1        = 1'b0;
    endtask

    // One clock cycle with the current inputs: predict, compare, advance model.
    task automatic applyStimulus();
        int g;
        @(negedge clk);
        g = 0;
        if (rstn) begin
            if (p0_req && !p1_req)      g = 1;
            else if (!p0_req && p1_req) g = 2;
            else if (p0_req && p1_req) begin
                if (m_prev_p1 && p1_lock && m_run < MAX_BURST) g = 2;
                else g = (m_last_owner == 1) ? 1 : 2;
            end
        end
        dut_g0 = p0_gnt;  dut_g1 = p1_gnt;
        dut_rv0 = p0_rvalid; dut_rv1 = p1_rvalid;
        dut_rdata = rdata; dut_conf = conflicts;

        checkOutput("p0_gnt", p0_gnt, 32'(g == 1));
        checkOutput("p1_gnt", p1_gnt, 32'(g == 2));
        checkOutput("ram_cs", ram_cs, 32'(g != 0));
        checkOutput("ram_rw", ram_rw, (g == 2) ? 32'(p1_rw) : (g == 1) ? 32'(p0_rw) : 32'd1);
        if (g != 0) begin
            checkOutput("ram_addr", ram_addr, (g == 2) ? 32'(p1_addr) : 32'(p0_addr));
            if (ram_rw == RW_WRITE)
                checkOutput("ram_din", ram_din, (g == 2) ? 32'(p1_wdata) : 32'(p0_wdata));
        end
        checkOutput("p0_rvalid", p0_rvalid, 32'(m_rv0 && rstn));
        checkOutput("p1_rvalid", p1_rvalid, 32'(m_rv1 && rstn));
        if (rstn && (m_rv0 || m_rv1)) checkOutput("rdata", rdata, 32'(m_rdata));
        checkOutput("conflicts", conflicts, 32'(m_conf));
        last_grant = g;

        if (!rstn) begin
            modelReset();
        end else begin
            if (p0_req && p1_req && m_conf < CNT_MAX) m_conf++;
            if (g == 1 || !p1_lock) m_run = 0;
            else if (g == 2 && p0_req && m_run < MAX_BURST) m_run++;
            m_rv0 = (g == 1) && p0_rw;
            m_rv1 = (g == 2) && p1_rw;
            if (g == 1) begin
                if (p0_rw) m_rdata = ref_mem[p0_addr];
                else       ref_mem[p0_addr] = p0_wdata;
            end else if (g == 2) begin
                if (p1_rw) m_rdata = ref_mem[p1_addr];
                else       ref_mem[p1_addr] = p1_wdata;
            end
            if (g != 0) m_last_owner = g - 1;
            m_prev_p1 = (g == 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setP0(input logic req, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        p0_req = req; p0_rw = rw; p0_addr = addr; p0_wdata = wdata;
    endtask

    task automatic setP1(input logic req, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        p1_req = req; p1_rw = rw; p1_addr = addr; p1_wdata = wdata;
    endtask

    task automatic doReset(input int n);
        rstn = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
        repeat (n) applyStimulus();
        rstn = 1'b1;
    endtask

    task automatic randReq0();
        setP0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    task automatic randReq1();
        setP1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seedVal(i);
        modelReset();
        m_rdata = '0;

        doReset(3);
        load_mem = 1'b0;
        checkOutput("rst_conflicts", dut_conf, 0);
        checkOutput("rst_p0_gnt", dut_g0, 0);

        // first access after reset: p0 read of 0x005
        setP0(1'b1, RW_READ, 9'h005, '0);
        applyStimulus();
        checkOutput("t1_p0_gnt", dut_g0, 1);
        p0_req = 1'b0;
        applyStimulus();
        checkOutput("t1_p0_rvalid", dut_rv0, 1);
        checkOutput("t1_rdata", dut_rdata, 32'(seedVal(5)));

        // p1 write then p0 read of the same word
        setP1(1'b1, RW_WRITE, 9'h010, 12'hABC);
        setP0(1'b1, RW_READ, 9'h010, '0);
        applyStimulus();
        checkOutput("t2_p1_gnt", dut_g1, 1);
        checkOutput("t2_p0_wait", dut_g0, 0);
        p1_req = 1'b0;
        applyStimulus();
        checkOutput("t2_p0_gnt", dut_g0, 1);
        p0_req = 1'b0;
        applyStimulus();
        checkOutput("t2_p0_rvalid", dut_rv0, 1);
        checkOutput("t2_rdata", dut_rdata, 32'hABC);

        // both held, no lock: strict alternation starting with port 0
        doReset(2);
        setP0(1'b1, RW_READ, 9'h001, '0);
        setP1(1'b1, RW_READ, 9'h002, '0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("t3_p0_gnt", dut_g0, 32'((i % 2) == 0));
            checkOutput("t3_p1_gnt", dut_g1, 32'((i % 2) == 1));
        end
        p0_req = 1'b0; p1_req = 1'b0;
        applyStimulus();
        checkOutput("t3_conflicts", dut_conf, 6);

        // lock burst: port 1 owns first, then 4 locked grants, p0, p1
        doReset(2);
        p1_lock = 1'b1;
        setP1(1'b1, RW_READ, 9'h020, '0);
        applyStimulus();
        checkOutput("t4_p1_own", dut_g1, 1);
        setP0(1'b1, RW_READ, 9'h021, '0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("t4_p0_gnt", dut_g0, 32'(i == 4));
            checkOutput("t4_p1_gnt", dut_g1, 32'(i != 4));
        end
        p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
        applyStimulus();

        // reset right after a p1 read grant drops the pending rvalid
        setP1(1'b1, RW_READ, 9'h003, '0);
        applyStimulus();
        checkOutput("t5_p1_gnt", dut_g1, 1);
        p1_req = 1'b0;
        rstn = 1'b0;
        applyStimulus();
        checkOutput("t5_rvalid_in_rst", dut_rv1, 0);
        rstn = 1'b1;
        applyStimulus();
        checkOutput("t5_rvalid_after", dut_rv1, 0);
        setP0(1'b1, RW_READ, 9'h004, '0);
        setP1(1'b1, RW_READ, 9'h005, '0);
        p1_lock = 1'b1;
        applyStimulus();
        checkOutput("t5_p0_first", dut_g0, 1);
        p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;

        // conflict counter saturation
        doReset(1);
        setP0(1'b1, RW_READ, 9'h006, '0);
        setP1(1'b1, RW_READ, 9'h007, '0);
        repeat (20) applyStimulus();
        p0_req = 1'b0; p1_req = 1'b0;
        applyStimulus();
        checkOutput("t6_conf_sat", dut_conf, 32'hF);

        // randomized traffic with occasional resets
        doReset(1);
        randReq0();
        randReq1();
        for (int c = 0; c < 3000; c++) begin
            rstn    = ($urandom_range(0, 199) != 0);
            p1_lock = ($urandom_range(0, 3) != 0);
            applyStimulus();
            if (last_grant == 1 || !p0_req) randReq0();
            if (last_grant == 2 || !p1_req) randReq1();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
